// File: rtl/cell_pkg.sv
// Shared cell geometry, scan location type, FSM state encoding and the
// shape bit-packing helper used by both the 5x5 plotter and reader.
package cell_pkg;

  localparam int CELL_DIM    = 5;
  localparam int CELL_PIXELS = CELL_DIM * CELL_DIM;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
  } cell_loc_t;

  localparam cell_loc_t LAST_LOC = '{row: 3'(CELL_DIM - 1), col: 3'(CELL_DIM - 1)};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Top-left pixel lands in the MSB so shapes read left-to-right as written.
  function automatic logic [4:0] bit_index(input logic [2:0] row, input logic [2:0] col);
    return 5'(CELL_PIXELS - 1 - (CELL_DIM * int'(row) + int'(col)));
  endfunction

endpackage

// File: rtl/cell_scan_counter.sv
// Row-major (col fastest) scan position over a 5x5 cell; wraps to (0,0)
// after the last location and flags when it sits on that last location.
module cell_scan_counter
  import cell_pkg::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  logic      clear,
  input  logic      enable,
  output cell_loc_t loc,
  output cell_loc_t next_loc,
  output logic      last
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_loc = loc;
    last     = (loc == LAST_LOC);
    if (last) begin
      next_loc = '0;
    end else if (loc.col == LAST_LOC.col) begin
      next_loc.col = '0;
      next_loc.row = loc.row + 3'd1;
    end else begin
      next_loc.col = loc.col + 3'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      loc <= '0;
    end else if (enable) begin
      loc <= next_loc;
    end
  end

endmodule

// File: rtl/cell_reader_5x5.sv
// Reads one 5x5 cell from a synchronous pixel memory into a 25-bit shape word.
// Optional CELL_READER_MATCH_EN: set a bit only where the pixel equals match_colour.
module cell_reader_5x5 #(
  parameter int CELL_DIM = 5,
  parameter int COL_W    = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       x_in,
  input  logic [6:0]       y_in,
  input  logic [COL_W-1:0] match_colour,
  output logic             rd_en,
  output logic [7:0]       rd_x,
  output logic [6:0]       rd_y,
  input  logic [COL_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [24:0]      shape
);

  import cell_pkg::*;

  state_t     state;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [7:0] x_scaled;
  logic [6:0] y_scaled;
  logic       accept;
  cell_loc_t  loc;
  cell_loc_t  next_loc;
  logic       last;
  logic       rd_en_d;
  logic [4:0] bit_d;
  logic       pix_bit;

  // Multiplying at the output width keeps exactly the low bits of the full product.
  assign x_scaled = 8'(x_in * 8'(CELL_DIM));
  assign y_scaled = 7'(y_in * 7'(CELL_DIM));
  assign accept   = (state == IDLE) && start;
  assign busy     = (state != IDLE);

  cell_scan_counter u_scan (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (accept),
    .enable   (state == READ),
    .loc      (loc),
    .next_loc (next_loc),
    .last     (last)
  );

`ifdef CELL_READER_MATCH_EN
  logic [COL_W-1:0] match_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      match_q <= '0;
    end else if (accept) begin
      match_q <= match_colour;
    end
  end

  assign pix_bit = (rd_data == match_q);
`else
  logic unused_match;

  assign unused_match = ^match_colour;
  assign pix_bit      = |rd_data;
`endif

  // Read data returns one cycle after its strobe, so the bit position trails by one.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_en_d <= 1'b0;
      bit_d   <= '0;
    end else begin
      rd_en_d <= rd_en;
      bit_d   <= bit_index(loc.row, loc.col);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      base_x <= '0;
      base_y <= '0;
      rd_en  <= 1'b0;
      rd_x   <= '0;
      rd_y   <= '0;
      done   <= 1'b0;
      shape  <= '0;
    end else begin
      if (rd_en_d) begin
        shape[bit_d] <= pix_bit;
      end
      case (state)
        IDLE: begin
          if (start) begin
            base_x <= x_scaled;
            base_y <= y_scaled;
            shape  <= '0;
            rd_en  <= 1'b1;
            rd_x   <= x_scaled;
            rd_y   <= y_scaled;
            state  <= READ;
          end
        end
        READ: begin
          if (last) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_x <= base_x + {5'd0, next_loc.col};
            rd_y <= base_y + {4'd0, next_loc.row};
          end
        end
        DRAIN: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_reader_5x5.sv
// Directed bench for cell_reader_5x5: a scoreboard of expected read addresses,
// shapes and done cycles is filled at each start and drained by an output monitor.
module tb_cell_reader_5x5;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  x_in = '0;
  logic [6:0]  y_in = '0;
  logic [2:0]  match_colour = '0;
  logic        rd_en;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic [2:0]  rd_data = '0;
  logic        busy;
  logic        done;
  logic [24:0] shape;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_count = 0;
  int mode = 0;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
  } addr_t;

  addr_t       addr_q[$];
  logic [24:0] shape_q[$];
  int          due_q[$];

  cell_reader_5x5 #(.CELL_DIM(5), .COL_W(3)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .x_in         (x_in),
    .y_in         (y_in),
    .match_colour (match_colour),
    .rd_en        (rd_en),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .shape        (shape)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pixel content: 0 solid, 1 diagonal, 2 alternating colours by column.
  function automatic logic [2:0] mem_pix(input logic [7:0] x, input logic [6:0] y, input int m);
    case (m)
      0:       return 3'b001;
      1:       return (int'(x) == int'(y)) ? 3'b101 : 3'b000;
      default: return x[0] ? 3'b001 : 3'b110;
    endcase
  endfunction

  function automatic logic pix_expect(input logic [2:0] p, input logic [2:0] mc);
`ifdef CELL_READER_MATCH_EN
    return p == mc;
`else
    return (mc == mc) && (|p);
`endif
  endfunction

  // Synchronous memory: data valid one cycle after the strobe, junk otherwise.
  always @(posedge clock) rd_data <= rd_en ? mem_pix(rd_x, rd_y, mode) : 3'b111;

  always @(negedge clock) begin
    addr_t       a;
    logic [24:0] s;
    int          due;
    if (rd_en === 1'b1) begin
      check("read_expected", addr_q.size() > 0, 1'b1);
      if (addr_q.size() > 0) begin
        a = addr_q.pop_front();
        check("rd_addr", {rd_x, rd_y}, a);
      end
    end
    if (done === 1'b1) begin
      done_count++;
      check("done_expected", shape_q.size() > 0, 1'b1);
      if (shape_q.size() > 0) begin
        s   = shape_q.pop_front();
        due = due_q.pop_front();
        check("shape", shape, s);
        check("done_cycle", cyc, due);
      end
    end
  end

  task automatic push_run(input logic [7:0] x, input logic [6:0] y, input int t);
    logic [24:0] s;
    addr_t       a;
    s = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        a.x = 8'((int'(x) * 5 + c) % 256);
        a.y = 7'((int'(y) * 5 + r) % 128);
        addr_q.push_back(a);
        s[24 - (5 * r + c)] = pix_expect(mem_pix(a.x, a.y, mode), match_colour);
      end
    end
    shape_q.push_back(s);
    due_q.push_back(t + 27);
  endtask

  task automatic one_read(input logic [7:0] x, input logic [6:0] y);
    push_run(x, y, cyc);
    x_in  = x;
    y_in  = y;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    x_in  = ~x;
    y_in  = ~y;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_drain(input int max_cycles);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clock);
      if (shape_q.size() == 0 && !busy && !done) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_in_time", ok, 1'b1);
  endtask

  initial begin
    int t;
    int d0;

    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_rd_en", rd_en, 1'b0);
    check("reset_rd_x", rd_x, 8'd0);
    check("reset_rd_y", rd_y, 7'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_shape", shape, 25'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Solid cell at (2,3): x 10..14, y 15..19.
    mode = 0; match_colour = 3'b001;
    one_read(8'd2, 7'd3);
    wait_drain(40);
    check("solid_shape_hold", shape, 25'h1FFFFFF);

    // Diagonal at origin.
    mode = 1; match_colour = 3'b101;
    one_read(8'd0, 7'd0);
    wait_drain(40);
    check("diag_shape_hold", shape, 25'b10000_01000_00100_00010_00001);

    // Alternating columns; match selects columns 0, 2, 4 only.
    mode = 2; match_colour = 3'b110;
    one_read(8'd0, 7'd0);
    wait_drain(40);

    // Address wrap: 300 mod 256 = 44, 150 mod 128 = 22.
    mode = 0; match_colour = 3'b001;
    one_read(8'd60, 7'd30);
    wait_drain(40);

    // Robustness: a second start mid-read is ignored, then reset aborts the read.
    mode = 0;
    push_run(8'd1, 7'd1, cyc);
    x_in = 8'd1; y_in = 7'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    start = 1'b1; x_in = 8'd9; y_in = 7'd9;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    addr_q.delete();
    shape_q.delete();
    due_q.delete();
    check("abort_busy", busy, 1'b0);
    check("abort_rd_en", rd_en, 1'b0);
    check("abort_shape", shape, 25'd0);
    check("abort_done", done, 1'b0);
    d0 = done_count;
    repeat (30) @(negedge clock);
    check("abort_no_done", done_count, d0);
    mode = 1; match_colour = 3'b101;
    one_read(8'd0, 7'd0);
    wait_drain(40);

    // Back-to-back: start held 60 cycles, accepted at T, T+28 and T+56.
    mode = 0; match_colour = 3'b001;
    t = cyc;
    push_run(8'd4, 7'd5, t);
    push_run(8'd4, 7'd5, t + 28);
    push_run(8'd4, 7'd5, t + 56);
    x_in = 8'd4; y_in = 7'd5;
    d0 = done_count;
    start = 1'b1;
    repeat (60) @(negedge clock);
    start = 1'b0;
    check("b2b_done_pulses", done_count - d0, 2);
    wait_drain(60);

    check("addr_queue_empty", addr_q.size(), 0);
    check("shape_queue_empty", shape_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
